// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU control sequencer: ALU operation codes,
// primary opcode values, FSM state encoding and the multi-cycle classifier.
package alu_ctrl_pkg;

    localparam int unsigned ALU_ADD = 0;
    localparam int unsigned ALU_SUB = 1;
    localparam int unsigned ALU_AND = 2;
    localparam int unsigned ALU_OR  = 3;
    localparam int unsigned ALU_XOR = 4;
    localparam int unsigned ALU_NOR = 5;
    localparam int unsigned ALU_SLT = 6;
    localparam int unsigned ALU_SLL = 7;
    localparam int unsigned ALU_SRL = 8;
    localparam int unsigned ALU_MUL = 9;
    localparam int unsigned ALU_DIV = 10;
    localparam int unsigned ALU_NOP = 15;

    localparam int unsigned OPS_RTYPE  = 0;
    localparam int unsigned OPS_ADD    = 1;
    localparam int unsigned OPS_AND    = 2;
    localparam int unsigned OPS_OR     = 3;
    localparam int unsigned OPS_LDST   = 4;
    localparam int unsigned OPS_BRANCH = 5;
    localparam int unsigned OPS_SLT    = 6;
    localparam int unsigned OPS_RSVD   = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    function automatic logic is_multi(input int unsigned code);
        return (code == ALU_MUL) || (code == ALU_DIV);
    endfunction

endpackage

// File: rtl/alu_ctrl_seq_decode.sv
// Combinational decode of primary opcode and R-type function field into an
// ALU operation code, an illegal-encoding flag and a multi-cycle flag.
module alu_ctrl_seq_decode
    import alu_ctrl_pkg::*;
#(
    parameter int OPS_W   = 3,
    parameter int FUNC_W  = 4,
    parameter int ALUOP_W = 4
) (
    input  logic [OPS_W-1:0]   ops,
    input  logic [FUNC_W-1:0]  func,
    output logic [ALUOP_W-1:0] aluop,
    output logic               illegal,
    output logic               multi
);

    int unsigned code;
    logic        bad;

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        code = ALU_NOP;
        bad  = 1'b0;
        case (32'(ops))
            OPS_RTYPE: begin
                if (32'(func) <= ALU_DIV) code = 32'(func);
                else                      bad  = 1'b1;
            end
            OPS_ADD, OPS_LDST: code = ALU_ADD;
            OPS_AND:           code = ALU_AND;
            OPS_OR:            code = ALU_OR;
            OPS_BRANCH:        code = ALU_SUB;
            OPS_SLT:           code = ALU_SLT;
            default:           bad  = 1'b1;
        endcase
    end

    assign aluop   = ALUOP_W'(code);
    assign illegal = bad;
    assign multi   = is_multi(code);

endmodule

// File: rtl/alu_ctrl_seq.sv
// ALU control sequencer: decodes ops/func, registers the result behind a
// valid/ready handshake and holds MUL/DIV for their latency.
// Optional performance counters are enabled with `define ALU_CTRL_PERF_EN.
module alu_ctrl_seq
    import alu_ctrl_pkg::*;
#(
    parameter int OPS_W   = 3,
    parameter int FUNC_W  = 4,
    parameter int ALUOP_W = 4,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 8,
    parameter int CNT_W   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OPS_W-1:0]   ops,
    input  logic [FUNC_W-1:0]  func,
    output logic [ALUOP_W-1:0] aluop,
    output logic               alu_start,
    output logic               alu_busy,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               illegal
`ifdef ALU_CTRL_PERF_EN
    ,
    output logic [15:0]        perf_ops,
    output logic [15:0]        perf_stall,
    output logic [7:0]         perf_illegal
`endif
);

    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic               start_q;
    logic [ALUOP_W-1:0] aluop_q;
    logic               illegal_q;
    logic               ready_int;
    logic               xfer;

    logic [ALUOP_W-1:0] dec_aluop;
    logic               dec_illegal;
    logic               dec_multi;

    alu_ctrl_seq_decode #(
        .OPS_W   (OPS_W),
        .FUNC_W  (FUNC_W),
        .ALUOP_W (ALUOP_W)
    ) u_decode (
        .ops     (ops),
        .func    (func),
        .aluop   (dec_aluop),
        .illegal (dec_illegal),
        .multi   (dec_multi)
    );

    always_comb begin
        ready_int = (state == ST_IDLE) || ((state == ST_OUT) && out_ready);
        xfer      = in_valid && ready_int;
        state_nxt = state;
        case (state)
            ST_IDLE: if (xfer) state_nxt = dec_multi ? ST_BUSY : ST_OUT;
            // Leave BUSY as the counter steps to 0, so OUT lands exactly LAT cycles after transfer.
            ST_BUSY: if (cnt <= CNT_W'(1)) state_nxt = ST_OUT;
            ST_OUT: begin
                if (out_ready) begin
                    if (xfer) state_nxt = dec_multi ? ST_BUSY : ST_OUT;
                    else      state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            start_q   <= 1'b0;
            aluop_q   <= ALUOP_W'(ALU_NOP);
            illegal_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            start_q <= xfer && dec_multi;
            if (xfer) begin
                aluop_q   <= dec_aluop;
                illegal_q <= dec_illegal;
                if (dec_multi)
                    cnt <= (dec_aluop == ALUOP_W'(ALU_MUL)) ? MUL_CNT : DIV_CNT;
                else
                    cnt <= '0;
            end else if (state == ST_BUSY) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    assign in_ready  = ready_int;
    assign aluop     = aluop_q;
    assign illegal   = illegal_q;
    assign alu_start = start_q;
    assign alu_busy  = (state == ST_BUSY);
    assign out_valid = (state == ST_OUT);

`ifdef ALU_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_ops     <= '0;
            perf_stall   <= '0;
            perf_illegal <= '0;
        end else begin
            if ((state == ST_OUT) && out_ready && (perf_ops != '1))
                perf_ops <= perf_ops + 16'd1;
            if (((state == ST_BUSY) || ((state == ST_OUT) && !out_ready)) && (perf_stall != '1))
                perf_stall <= perf_stall + 16'd1;
            if (xfer && dec_illegal && (perf_illegal != '1))
                perf_illegal <= perf_illegal + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Self-checking bench for alu_ctrl_seq: directed scenarios with literal
// expectations plus randomized traffic checked against a transaction model.
module tb_alu_ctrl_seq;

    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] ops = '0;
    logic [3:0] func = '0;
    logic [3:0] aluop;
    logic       alu_start;
    logic       alu_busy;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       illegal;
`ifdef ALU_CTRL_PERF_EN
    logic [15:0] perf_ops;
    logic [15:0] perf_stall;
    logic [7:0]  perf_illegal;
`endif

    int checks = 0;
    int errors = 0;

    alu_ctrl_seq #(
        .OPS_W   (3),
        .FUNC_W  (4),
        .ALUOP_W (4),
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT),
        .CNT_W   (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ops       (ops),
        .func      (func),
        .aluop     (aluop),
        .alu_start (alu_start),
        .alu_busy  (alu_busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .illegal   (illegal)
`ifdef ALU_CTRL_PERF_EN
        ,
        .perf_ops     (perf_ops),
        .perf_stall   (perf_stall),
        .perf_illegal (perf_illegal)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Spec decode tables: ops 0 is func-driven, ops 7 illegal.
    function automatic int ref_code(input int o, input int f);
        int tab[8] = '{-1, 0, 2, 3, 0, 1, 6, 15};
        if (o == 0) return (f <= 10) ? f : 15;
        return tab[o];
    endfunction

    function automatic bit ref_illegal(input int o, input int f);
        return (o == 7) || (o == 0 && f > 10);
    endfunction

    // Transaction model: one pending op, visible from ready_cyc onward.
    bit      armed = 0;
    bit      pend = 0;
    longint  cyc = 0;
    longint  ready_cyc = 0;
    longint  start_cyc = -1;
    int      m_aluop = 15;
    bit      m_ill = 0;
    int      m_pops = 0, m_pstall = 0, m_pill = 0;

    always @(negedge clk) begin
        bit exp_ov, exp_busy, exp_start, exp_ir, hs, xf;
        int code, lat;
        exp_ov    = pend && (cyc >= ready_cyc);
        exp_busy  = pend && (cyc < ready_cyc);
        exp_start = pend && (cyc == start_cyc);
        exp_ir    = !pend || (exp_ov && out_ready);
        if (armed) begin
            check("out_valid", 32'(out_valid), 32'(exp_ov));
            check("alu_busy",  32'(alu_busy),  32'(exp_busy));
            check("alu_start", 32'(alu_start), 32'(exp_start));
            check("in_ready",  32'(in_ready),  32'(exp_ir));
            check("aluop",     32'(aluop),     m_aluop);
            check("illegal",   32'(illegal),   32'(m_ill));
`ifdef ALU_CTRL_PERF_EN
            check("perf_ops",     32'(perf_ops),     m_pops);
            check("perf_stall",   32'(perf_stall),   m_pstall);
            check("perf_illegal", 32'(perf_illegal), m_pill);
`endif
        end
        if (!rst_n) begin
            pend = 0; m_aluop = 15; m_ill = 0; start_cyc = -1;
            m_pops = 0; m_pstall = 0; m_pill = 0;
            armed = 1;
        end else if (armed) begin
            hs = exp_ov && out_ready;
            xf = in_valid && exp_ir;
            if (hs && m_pops < 65535) m_pops++;
            if ((exp_busy || (exp_ov && !out_ready)) && m_pstall < 65535) m_pstall++;
            if (xf && ref_illegal(int'(ops), int'(func)) && m_pill < 255) m_pill++;
            if (hs) pend = 0;
            if (xf) begin
                code      = ref_code(int'(ops), int'(func));
                lat       = (code == 9) ? MUL_LAT : (code == 10) ? DIV_LAT : 1;
                pend      = 1;
                m_aluop   = code;
                m_ill     = ref_illegal(int'(ops), int'(func));
                ready_cyc = cyc + lat;
                start_cyc = (lat > 1) ? cyc + 1 : -1;
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input bit v, input int o, input int f, input bit r);
        in_valid  = v;
        ops       = 3'(o);
        func      = 4'(f);
        out_ready = r;
    endtask

    task automatic wait_out(output int n);
        n = 1;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        int o, f;

        // Reset state
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        check("rst out_valid", 32'(out_valid), 0);
        check("rst aluop",     32'(aluop),     15);
        check("rst illegal",   32'(illegal),   0);
        check("rst alu_busy",  32'(alu_busy),  0);
        check("rst in_ready",  32'(in_ready),  1);

        // OR via ops=3, func ignored
        set_in(1, 3, 6, 1); tick();
        check("or out_valid", 32'(out_valid), 1);
        check("or aluop",     32'(aluop),     3);
        check("or illegal",   32'(illegal),   0);

        // ADD, then DIV with full latency
        set_in(1, 1, 10, 1); tick();
        check("add aluop", 32'(aluop), 0);
        set_in(1, 0, 10, 1); tick();
        set_in(0, 0, 0, 1);
        check("div start",    32'(alu_start), 1);
        check("div busy",     32'(alu_busy),  1);
        check("div in_ready", 32'(in_ready),  0);
        tick();
        check("div start once", 32'(alu_start), 0);
        wait_out(n);
        check("div latency", n + 1, DIV_LAT);
        check("div aluop",   32'(aluop), 10);
        tick();

        // MUL held in OUT while stalled, then back-to-back accept
        set_in(1, 0, 9, 0); tick();
        set_in(0, 0, 0, 0);
        wait_out(n);
        check("mul latency", n, MUL_LAT);
        set_in(1, 2, 0, 0);
        for (int i = 0; i < 3; i++) begin
            check("hold aluop",    32'(aluop),    9);
            check("hold in_ready", 32'(in_ready), 0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("b2b in_ready", 32'(in_ready), 1);
        tick();
        check("b2b aluop",     32'(aluop),     2);
        check("b2b out_valid", 32'(out_valid), 1);

        // Illegal encodings
        set_in(1, 7, 0, 1); tick();
        check("ops7 aluop",   32'(aluop),   15);
        check("ops7 illegal", 32'(illegal), 1);
        set_in(1, 0, 13, 1); tick();
        check("func13 aluop",   32'(aluop),     15);
        check("func13 illegal", 32'(illegal),   1);
        check("func13 valid",   32'(out_valid), 1);
        set_in(1, 1, 0, 1); tick();
        check("legal again", 32'(illegal), 0);
        set_in(0, 0, 0, 1); tick();

        // Reset during third BUSY cycle of DIV
        set_in(1, 0, 10, 1); tick();
        set_in(0, 0, 0, 1); tick(); tick();
        rst_n = 1'b0; tick();
        rst_n = 1'b1;
        check("mid rst out_valid", 32'(out_valid), 0);
        check("mid rst busy",      32'(alu_busy),  0);
        check("mid rst aluop",     32'(aluop),     15);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid) n++;
        end
        check("no spurious out_valid", n, 0);

        // Stream 20 single-cycle ops
        for (int i = 0; i < 20; i++) begin
            o = $urandom_range(1, 6);
            set_in(1, o, $urandom_range(0, 15), 1);
            tick();
            check("stream valid", 32'(out_valid), 1);
        end
        set_in(0, 0, 0, 1); tick();
`ifdef ALU_CTRL_PERF_EN
        check("stream perf_ops",   32'(perf_ops),   20);
        check("stream perf_stall", 32'(perf_stall), 0);
`endif

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                o = 0;
                f = $urandom_range(9, 10);
            end else begin
                o = $urandom_range(0, 7);
                f = $urandom_range(0, 15);
            end
            set_in($urandom_range(0, 9) < 7, o, f, $urandom_range(0, 9) < 7);
            rst_n = ($urandom_range(0, 149) != 0);
            tick();
        end
        rst_n = 1'b1;
        set_in(0, 0, 0, 1);
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
